window_ctrl: RTL and testbench

//   Line-buffer controller for the Harris pipeline: takes a raster pixel stream, stores it in NBUF

---
 rtl/win_pkg.sv | 36 +++
 rtl/window_ctrl_line_store.sv | 42 ++++
 rtl/window_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_window_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// -----------------------------------------------------------------------------
// win_pkg
//   Shared constants, derived widths, FSM state type and a modulo-NBUF helper
//   for the window_ctrl line-buffer controller and its line_store RAMs.
//   No ports (package).
// -----------------------------------------------------------------------------
package win_pkg;

  localparam int IMG_W = 480;  // pixels per image line
  localparam int WIN   = 6;    // window height and width
  localparam int DW    = 8;    // bits per pixel
  localparam int NBUF  = 7;    // line stores: one being written, WIN being read

  localparam int COL_W  = $clog2(IMG_W);
  localparam int FILL_W = $clog2(NBUF * IMG_W + 1);
  localparam int SEL_W  = $clog2(NBUF);

  localparam int LAST_COL = IMG_W - WIN;   // left column of the final window in a line
  localparam int FILL_MAX = NBUF * IMG_W;  // every store holds a full line
  localparam int FILL_RD  = WIN * IMG_W;   // enough whole lines to read a window row set

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_e;

  // Store index sel+step wrapped into 0..NBUF-1; step is always below NBUF.
  function automatic logic [SEL_W-1:0] sel_add(input logic [SEL_W-1:0] sel,
                                               input int step);
    int sum;
    sum = int'(sel) + step;
    if (sum >= NBUF) sum = sum - NBUF;
    return SEL_W'(sum);
  endfunction

endpackage : win_pkg

// File: rtl/window_ctrl_line_store.sv
// -----------------------------------------------------------------------------
// line_store
//   One image line of pixel storage (IMG_W x DW). Synchronous single-pixel
//   write; combinational read of WIN adjacent pixels starting at a column.
//   Ports:
//     i_clk      clock
//     i_we       write enable
//     i_wr_col   write column
//     i_wr_data  write pixel
//     i_rd_col   leftmost read column (at most IMG_W-WIN)
//     o_taps     WIN pixels; pixel c at [c*DW +: DW]
// -----------------------------------------------------------------------------
module line_store
  import win_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [COL_W-1:0]  i_wr_col,
  input  logic [DW-1:0]     i_wr_data,
  input  logic [COL_W-1:0]  i_rd_col,
  output logic [WIN*DW-1:0] o_taps
);

  logic [DW-1:0] mem_q [IMG_W];

  // NOTE: the RAM array is deliberately not reset; the fill counter guarantees
  // no location is read before it has been written, so a reset would only
  // stop the array mapping onto a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_wr_col] <= i_wr_data;
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    o_taps = '0;
    for (int c = 0; c < WIN; c++) begin
      o_taps[c*DW +: DW] = mem_q[i_rd_col + COL_W'(c)];
    end
  end

endmodule : line_store

// File: rtl/window_ctrl.sv
// -----------------------------------------------------------------------------
// window_ctrl
//   Line-buffer controller: stores a raster pixel stream in NBUF rotating
//   line stores and emits one WIN x WIN window per accepted output beat.
//   Owns fill tracking, store rotation, the output handshake and the
//   "line freed" interrupt.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_pixel_data     input pixel (DW)
//     i_pixel_valid    pixel strobe, no upstream backpressure
//     o_window_data    window; pixel(r,c) at [(r*WIN+c)*DW +: DW],
//                      row 0 = oldest line
//     o_window_valid   window beat valid
//     i_win_ready      downstream accepts when valid & ready
//     o_intr           1-cycle pulse when a line store is freed
//     o_overflow       sticky: a pixel arrived with every store full
//   Configuration macro: WINDOW_CTRL_INTR_EN. When undefined, o_intr is tied
//   low and its register is not built.
// -----------------------------------------------------------------------------
module window_ctrl
  import win_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DW-1:0]         i_pixel_data,
  input  logic                  i_pixel_valid,
  output logic [WIN*WIN*DW-1:0] o_window_data,
  output logic                  o_window_valid,
  input  logic                  i_win_ready,
  output logic                  o_intr,
  output logic                  o_overflow
);

  // Write side
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              overflow_q;
  logic              store_full;
  logic              wr_accept;

  // Read side
  state_e                state_q;
  logic [COL_W-1:0]      rd_col_q;
  logic [SEL_W-1:0]      rd_sel_q;
  logic [WIN*WIN*DW-1:0] win_data_q;
  logic                  win_valid_q;
  logic [WIN*WIN*DW-1:0] win_tap;
  logic                  load;
  logic                  eol;

  logic [WIN*DW-1:0] taps [NBUF];

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    store_full = (fill_cnt_q == FILL_W'(FILL_MAX));
    wr_accept  = i_pixel_valid && !store_full;
    // The output register is refilled whenever it is empty or being drained.
    load       = (state_q == RD) && (!win_valid_q || i_win_ready);
    eol        = load && (rd_col_q == COL_W'(LAST_COL));
  end

  // ---------------------------------------------------------------------------
  // Write pointer and fill counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_col_d   = wr_col_q;
    wr_sel_d   = wr_sel_q;
    fill_cnt_d = fill_cnt_q;
    if (wr_accept) begin
      if (wr_col_q == COL_W'(IMG_W - 1)) begin
        wr_col_d = '0;
        wr_sel_d = sel_add(wr_sel_q, 1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
      fill_cnt_d = fill_cnt_d + FILL_W'(1);
    end
    // Finishing a read line frees one whole store; a write in the same cycle
    // nets +1-IMG_W.
    if (eol) fill_cnt_d = fill_cnt_d - FILL_W'(IMG_W);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_col_q   <= '0;
      wr_sel_q   <= '0;
      fill_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_col_q   <= wr_col_d;
      wr_sel_q   <= wr_sel_d;
      fill_cnt_q <= fill_cnt_d;
      if (i_pixel_valid && store_full) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line stores
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NBUF; b++) begin : g_store
    line_store u_store (
      .i_clk     (i_clk),
      .i_we      (wr_accept && (wr_sel_q == SEL_W'(b))),
      .i_wr_col  (wr_col_q),
      .i_wr_data (i_pixel_data),
      .i_rd_col  (rd_col_q),
      .o_taps    (taps[b])
    );
  end

  // Row r of the window comes from store rd_sel+r, so row 0 is the oldest line.
  always_comb begin
    win_tap = '0;
    for (int r = 0; r < WIN; r++) begin
      win_tap[r*WIN*DW +: WIN*DW] = taps[sel_add(rd_sel_q, r)];
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM with registered window outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rd_col_q    <= '0;
      rd_sel_q    <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Drain the last beat of the previous line; no new loads here.
          if (win_valid_q && i_win_ready) win_valid_q <= 1'b0;
          if (fill_cnt_q >= FILL_W'(FILL_RD)) state_q <= RD;
        end
        RD: begin
          if (load) begin
            win_data_q  <= win_tap;
            win_valid_q <= 1'b1;
            if (eol) begin
              rd_col_q <= '0;
              rd_sel_q <= sel_add(rd_sel_q, 1);
              state_q  <= IDLE;
            end else begin
              rd_col_q <= rd_col_q + COL_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line-freed interrupt
  // ---------------------------------------------------------------------------
`ifdef WINDOW_CTRL_INTR_EN
  logic intr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) intr_q <= 1'b0;
    else          intr_q <= eol;
  end

  assign o_intr = intr_q;
`else
  assign o_intr = 1'b0;
`endif

  assign o_window_data  = win_data_q;
  assign o_window_valid = win_valid_q;
  assign o_overflow     = overflow_q;

  // A write landing on the end-of-line cycle must net exactly +1-IMG_W.
  a_fill_simul : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (eol && wr_accept) |=>
      (fill_cnt_q == $past(fill_cnt_q) + FILL_W'(1) - FILL_W'(IMG_W)));

endmodule : window_ctrl

// File: tb/tb_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_ctrl
//   Self-checking bench for window_ctrl. A reference model keeps every stored
//   pixel of the image in a queue and derives the expected window for the
//   n-th accepted beat directly from line/column arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_window_ctrl;

  localparam int W    = 480;
  localparam int K    = 6;
  localparam int PW   = 8;
  localparam int NS   = 7;
  localparam int NWIN = W - K + 1;
  localparam int WINW = K * K * PW;

  logic            clk;
  logic            rst_n;
  logic [PW-1:0]   pixel_data;
  logic            pixel_valid;
  logic [WINW-1:0] window_data;
  logic            window_valid;
  logic            win_ready;
  logic            intr;
  logic            overflow;

  window_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pixel_data   (pixel_data),
    .i_pixel_valid  (pixel_valid),
    .o_window_data  (window_data),
    .o_window_valid (window_valid),
    .i_win_ready    (win_ready),
    .o_intr         (intr),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [PW-1:0] img [$];      // every pixel the DUT is expected to have stored
  int beats_done    = 0;       // accepted output beats
  int intr_seen     = 0;
  int beats_at_intr = -1;

  // Expected window for the idx-th accepted beat: output line l covers image
  // lines l..l+K-1, and the beat's column is its position within that line.
  function automatic logic [WINW-1:0] exp_win(input int idx);
    logic [WINW-1:0] w;
    int l;
    int col;
    l   = idx / NWIN;
    col = idx % NWIN;
    w   = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*PW +: PW] = img[(l + r) * W + col + c];
    return w;
  endfunction

  function automatic bit beat_possible(input int idx);
    return ((idx / NWIN) + K) * W <= img.size();
  endfunction

  // One clock: drive inputs, score any accepted beat at the falling edge,
  // then return 1 ns after the next rising edge.
  task automatic run_cycle(input bit pv, input logic [PW-1:0] pd, input bit rdy,
                           input bit push);
    pixel_valid = pv;
    pixel_data  = pd;
    win_ready   = rdy;
    @(negedge clk);
    if (pv && push) img.push_back(pd);
    if (window_valid && rdy) begin
      vectors++;
      if (!beat_possible(beats_done)) begin
        miscompares++;
        $display("FAIL beat_unexpected: beat %0d seen, only %0d pixels stored",
                 beats_done, img.size());
      end else if (window_data !== exp_win(beats_done)) begin
        miscompares++;
        $display("FAIL beat_data[%0d]: got %h expected %h",
                 beats_done, window_data, exp_win(beats_done));
      end
      beats_done++;
    end
    if (intr === 1'b1) begin
      intr_seen++;
      beats_at_intr = beats_done;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    win_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({window_valid, intr, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {window_valid, intr, overflow});
    end
    vectors++;
    if (window_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", window_data);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (window_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_valid: got %b expected 0", window_valid);
    end
  endtask

  task automatic test_fill();
    logic [WINW-1:0] want;
    for (int l = 0; l < K; l++)
      for (int col = 0; col < W; col++)
        run_cycle(1'b1, PW'(l * 16 + (col % 16)), 1'b0, 1'b1);
    for (int i = 0; i < 20 && !window_valid; i++) run_cycle(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (window_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_valid: got %b expected 1", window_valid);
    end
    want = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) want[(r*K+c)*PW +: PW] = PW'(r * 16 + c);
    vectors++;
    if (window_data !== want) begin
      miscompares++;
      $display("FAIL fill_first_window: got %h expected %h", window_data, want);
    end
  endtask

  task automatic test_line_turn();
    intr_seen     = 0;
    beats_at_intr = -1;
    for (int col = 0; col < W; col++)
      run_cycle(1'b1, PW'(96 + (col % 16)), 1'b1, 1'b1);
    for (int i = 0; i < 300 && beats_done < NWIN + 1; i++)
      run_cycle(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (beats_done != NWIN + 1) begin
      miscompares++;
      $display("FAIL turn_beats: got %0d expected %0d", beats_done, NWIN + 1);
    end
`ifdef WINDOW_CTRL_INTR_EN
    vectors++;
    if (intr_seen != 1 || beats_at_intr != NWIN) begin
      miscompares++;
      $display("FAIL turn_intr: pulses %0d after beat %0d, expected 1 after %0d",
               intr_seen, beats_at_intr, NWIN);
    end
`else
    vectors++;
    if (intr_seen != 0) begin
      miscompares++;
      $display("FAIL turn_intr_off: got %0d pulses expected 0", intr_seen);
    end
`endif
  endtask

  task automatic test_backpressure();
    int b0;
    int n;
    n = $urandom_range(20, 60);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if (window_valid !== 1'b1 || window_data !== exp_win(beats_done)) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid %b data %h expected valid 1 data %h",
                 i, window_valid, window_data, exp_win(beats_done));
      end
    end
    b0 = beats_done;
    for (int i = 0; i < 100; i++) run_cycle(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (beats_done != b0 + 100) begin
      miscompares++;
      $display("FAIL stall_resume_count: got %0d expected %0d", beats_done, b0 + 100);
    end
  endtask

  task automatic test_random_stream();
    int sent;
    int target;
    bit pv;
    sent = 0;
    while (sent < 6 * W) begin
      pv = ($urandom_range(0, 9) < 7);
      run_cycle(pv, PW'($urandom), ($urandom_range(0, 9) < 9), 1'b1);
      if (pv) sent++;
    end
    target = ((img.size() / W) - K + 1) * NWIN;
    for (int i = 0; i < 5000 && beats_done < target; i++)
      run_cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (50) run_cycle(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (beats_done != target) begin
      miscompares++;
      $display("FAIL random_beats: got %0d expected %0d", beats_done, target);
    end
    vectors++;
    if (window_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drained: valid %b overflow %b expected 0 0",
               window_valid, overflow);
    end
  endtask

  task automatic test_overflow();
    rst_n = 1'b0;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    img.delete();
    beats_done = 0;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < NS * W; i++) run_cycle(1'b1, PW'($urandom), 1'b0, 1'b1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early: got %b expected 0", overflow);
    end
    run_cycle(1'b1, PW'($urandom), 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < 5; i++) run_cycle(1'b1, PW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3000 && beats_done < 2 * NWIN; i++)
      run_cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (50) run_cycle(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (beats_done != 2 * NWIN) begin
      miscompares++;
      $display("FAIL ovf_beats: got %0d expected %0d", beats_done, 2 * NWIN);
    end
    vectors++;
    if (overflow !== 1'b1 || window_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky: overflow %b valid %b expected 1 0", overflow, window_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int col = 0; col < W; col++) run_cycle(1'b1, PW'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 10 && !window_valid; i++) run_cycle(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (window_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre_valid: got %b expected 1", window_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({window_valid, intr, overflow} !== 3'b000 || window_data !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: flags %b data %h expected 000 and 0",
               {window_valid, intr, overflow}, window_data);
    end
    @(posedge clk);
    #1;
    run_cycle(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (window_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle: valid %b overflow %b expected 0 0", window_valid, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_line_turn();
    test_backpressure();
    test_random_stream();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_window_ctrl
